// File: rtl/dft_result_reader.sv
// Snapshots a frame of DFT accumulators and streams it out one bin per
// valid/ready transfer, with |A|^2 power on truncated components.
module dft_result_reader #(
  parameter int ACCUM_WIDTH  = 48,
  parameter int NUM_BINS     = 16,
  parameter int MAG_IN_WIDTH = 24,
  parameter int IDX_WIDTH    = $clog2(NUM_BINS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            frame_valid_i,
  input  logic [ACCUM_WIDTH*NUM_BINS-1:0] A_real_i,
  input  logic [ACCUM_WIDTH*NUM_BINS-1:0] A_imag_i,
  input  logic                            clear_i,
  input  logic                            ready_i,
  output logic                            valid_o,
  output logic [IDX_WIDTH-1:0]            bin_o,
  output logic [ACCUM_WIDTH-1:0]          real_o,
  output logic [ACCUM_WIDTH-1:0]          imag_o,
  output logic [2*MAG_IN_WIDTH-1:0]       power_o,
  output logic                            last_o,
  output logic                            busy_o,
  output logic                            overrun_o,
  output logic [7:0]                      overrun_cnt_o
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BINS - 1);

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t                    state_reg, state_next;
  logic                      valid_reg, valid_next;
  logic                      overrun_reg, overrun_next;
  logic [7:0]                cnt_reg, cnt_next;
  logic [IDX_WIDTH-1:0]      bin_reg;
  logic [ACCUM_WIDTH-1:0]    real_reg, imag_reg;
  logic [2*MAG_IN_WIDTH-1:0] power_reg;
  logic                      last_reg;

  logic [ACCUM_WIDTH-1:0] in_real [NUM_BINS];
  logic [ACCUM_WIDTH-1:0] in_imag [NUM_BINS];
  logic [ACCUM_WIDTH-1:0] buf_real_reg [NUM_BINS];
  logic [ACCUM_WIDTH-1:0] buf_imag_reg [NUM_BINS];

  logic snap_en, load_en, load_first, xfer;

  logic        [IDX_WIDTH-1:0]      load_idx;
  logic        [ACCUM_WIDTH-1:0]    load_real, load_imag;
  logic signed [MAG_IN_WIDTH-1:0]   mag_r, mag_i;
  logic signed [2*MAG_IN_WIDTH-1:0] sq_r, sq_i;
  logic        [2*MAG_IN_WIDTH-1:0] power_next;

  // Snapshot buffer: one register pair per bin, written only on frame accept
  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
    assign in_real[gi] = A_real_i[gi*ACCUM_WIDTH +: ACCUM_WIDTH];
    assign in_imag[gi] = A_imag_i[gi*ACCUM_WIDTH +: ACCUM_WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        buf_real_reg[gi] <= '0;
        buf_imag_reg[gi] <= '0;
      end else if (snap_en) begin
        buf_real_reg[gi] <= in_real[gi];
        buf_imag_reg[gi] <= in_imag[gi];
      end
    end
  end

  assign xfer = valid_reg && ready_i;

  always_comb begin
    state_next   = state_reg;
    valid_next   = valid_reg;
    overrun_next = 1'b0;
    cnt_next     = cnt_reg;
    snap_en      = 1'b0;
    load_en      = 1'b0;
    load_first   = 1'b0;
    if (clear_i) begin
      state_next = IDLE;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (frame_valid_i) begin
            snap_en    = 1'b1;
            load_en    = 1'b1;
            load_first = 1'b1;
            valid_next = 1'b1;
            state_next = STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (!last_reg) begin
              load_en = 1'b1;
            end else if (frame_valid_i) begin
              // Back-to-back frame: restart at bin 0 without dropping valid
              snap_en    = 1'b1;
              load_en    = 1'b1;
              load_first = 1'b1;
            end else begin
              state_next = IDLE;
              valid_next = 1'b0;
            end
          end
          if (frame_valid_i && !(xfer && last_reg)) begin
            overrun_next = 1'b1;
            if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
          end
        end
        default: begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  // Bin 0 comes straight from the inputs since the buffer fills on the same edge
  always_comb begin
    load_idx   = load_first ? '0 : bin_reg + 1'b1;
    load_real  = load_first ? in_real[0] : buf_real_reg[load_idx];
    load_imag  = load_first ? in_imag[0] : buf_imag_reg[load_idx];
    mag_r      = load_real[ACCUM_WIDTH-1 -: MAG_IN_WIDTH];
    mag_i      = load_imag[ACCUM_WIDTH-1 -: MAG_IN_WIDTH];
    sq_r       = mag_r * mag_r;
    sq_i       = mag_i * mag_i;
    power_next = $unsigned(sq_r) + $unsigned(sq_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      cnt_reg     <= '0;
      bin_reg     <= '0;
      real_reg    <= '0;
      imag_reg    <= '0;
      power_reg   <= '0;
      last_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      cnt_reg     <= cnt_next;
      if (load_en) begin
        bin_reg   <= load_idx;
        real_reg  <= load_real;
        imag_reg  <= load_imag;
        power_reg <= power_next;
        last_reg  <= (load_idx == LAST_IDX);
      end else if (!valid_next) begin
        last_reg  <= 1'b0;
      end
    end
  end

  assign valid_o       = valid_reg;
  assign bin_o         = bin_reg;
  assign real_o        = real_reg;
  assign imag_o        = imag_reg;
  assign power_o       = power_reg;
  assign last_o        = last_reg;
  assign busy_o        = (state_reg == STREAM);
  assign overrun_o     = overrun_reg;
  assign overrun_cnt_o = cnt_reg;

endmodule

// File: tb/tb_dft_result_reader.sv
// Bench for dft_result_reader: directed scenarios plus random traffic, checked
// against a queue of expected beats built from accepted frames.
module tb_dft_result_reader;

  localparam int AW = 48;
  localparam int NB = 16;
  localparam int MW = 24;
  localparam int IW = $clog2(NB);

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            frame_valid_i, clear_i, ready_i;
  logic [AW*NB-1:0] a_real, a_imag;
  logic            valid_o, last_o, busy_o, overrun_o;
  logic [IW-1:0]   bin_o;
  logic [AW-1:0]   real_o, imag_o;
  logic [2*MW-1:0] power_o;
  logic [7:0]      overrun_cnt_o;

  dft_result_reader #(.ACCUM_WIDTH(AW), .NUM_BINS(NB), .MAG_IN_WIDTH(MW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .frame_valid_i(frame_valid_i),
    .A_real_i(a_real), .A_imag_i(a_imag), .clear_i(clear_i), .ready_i(ready_i),
    .valid_o(valid_o), .bin_o(bin_o), .real_o(real_o), .imag_o(imag_o),
    .power_o(power_o), .last_o(last_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .overrun_cnt_o(overrun_cnt_o)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] cur_re [NB];
  logic [AW-1:0] cur_im [NB];

  always_comb begin
    a_real = '0;
    a_imag = '0;
    for (int k = 0; k < NB; k++) begin
      a_real[k*AW +: AW] = cur_re[k];
      a_imag[k*AW +: AW] = cur_im[k];
    end
  end

  typedef struct {
    int            bin;
    logic [AW-1:0] re;
    logic [AW-1:0] im;
  } beat_t;

  beat_t q[$];
  bit    exp_ovr;
  int    exp_cnt;
  int    n_pass = 0;
  int    n_total = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  function automatic longint pw(input logic [AW-1:0] re, input logic [AW-1:0] im);
    longint r, i;
    r = longint'($signed(re[AW-1 -: MW]));
    i = longint'($signed(im[AW-1 -: MW]));
    return r * r + i * i;
  endfunction

  task automatic check_outputs();
    bit v;
    v = (q.size() > 0);
    check_val("valid", valid_o, v);
    check_val("busy", busy_o, v);
    check_val("overrun", overrun_o, exp_ovr);
    check_val("ovr_cnt", overrun_cnt_o, exp_cnt);
    if (v) begin
      check_val("bin", bin_o, q[0].bin);
      check_val("real", real_o, q[0].re);
      check_val("imag", imag_o, q[0].im);
      check_val("power", power_o, pw(q[0].re, q[0].im));
      check_val("last", last_o, q[0].bin == NB - 1);
    end else begin
      check_val("last", last_o, 0);
    end
  endtask

  task automatic check_zero();
    check_val("rst_valid", valid_o, 0);
    check_val("rst_bin", bin_o, 0);
    check_val("rst_real", real_o, 0);
    check_val("rst_imag", imag_o, 0);
    check_val("rst_power", power_o, 0);
    check_val("rst_last", last_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_overrun", overrun_o, 0);
    check_val("rst_cnt", overrun_cnt_o, 0);
  endtask

  // One clock: update the model from the inputs, then compare at the next negedge
  task automatic step(input bit rdy, input bit fv, input bit clr);
    ready_i       = rdy;
    frame_valid_i = fv;
    clear_i       = clr;
    exp_ovr       = 1'b0;
    if (clr) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (fv) begin
        if (q.size() == 0) begin
          for (int k = 0; k < NB; k++) q.push_back('{k, cur_re[k], cur_im[k]});
        end else begin
          exp_ovr = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    frame_valid_i = 1'b0;
    clear_i       = 1'b0;
    check_outputs();
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * NB && q.size() > 0; n++) step(1'b1, 1'b0, 1'b0);
    check_val("drained", q.size(), 0);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NB; k++) begin
      cur_re[k] = AW'(longint'(k) << 24);
      cur_im[k] = AW'(-(longint'(k) << 24));
    end
  endtask

  function automatic logic [AW-1:0] rand_val();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0:       return 48'h8000_0000_0000;
      1:       return 48'h7FFF_FFFF_FFFF;
      2:       return AW'($signed(w[15:0]));
      default: return w[AW-1:0];
    endcase
  endfunction

  task automatic set_random();
    for (int k = 0; k < NB; k++) begin
      cur_re[k] = rand_val();
      cur_im[k] = rand_val();
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    check_zero();
    q.delete();
    exp_cnt = 0;
    exp_ovr = 1'b0;
    @(negedge clk);
    check_zero();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    frame_valid_i = 1'b0;
    clear_i = 1'b0;
    ready_i = 1'b0;
    exp_cnt = 0;
    exp_ovr = 1'b0;
    set_ramp();
    repeat (3) @(negedge clk);
    do_reset();

    // ramp frame, always ready
    step(1'b1, 1'b1, 1'b0);
    drain();
    $display("scenario ramp_ready done");

    // ready toggling every cycle
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 4 * NB && q.size() > 0; n++) step(n[0], 1'b0, 1'b0);
    check_val("toggle_drained", q.size(), 0);
    $display("scenario ready_toggle done");

    // full-scale negative bin 0
    cur_re[0] = 48'h8000_0000_0000;
    cur_im[0] = 48'h8000_0000_0000;
    step(1'b0, 1'b1, 1'b0);
    check_val("fullscale_power", power_o, 48'h8000_0000_0000);
    drain();
    $display("scenario full_scale done");

    // overrun at beat 5, then saturation
    set_ramp();
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 1'b0);
    set_random();
    step(1'b1, 1'b1, 1'b0);
    check_val("overrun_cnt_one", overrun_cnt_o, 1);
    drain();
    step(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 300; n++) step(1'b0, 1'b1, 1'b0);
    check_val("overrun_sat", overrun_cnt_o, 255);
    drain();
    $display("scenario overrun done");

    // back-to-back frame on the last-beat transfer
    set_ramp();
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < NB - 1; n++) step(1'b1, 1'b0, 1'b0);
    set_random();
    step(1'b1, 1'b1, 1'b0);
    check_val("b2b_bin0", bin_o, 0);
    drain();
    $display("scenario back_to_back done");

    // clear at beat 7 with a coincident frame pulse
    set_ramp();
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 7; n++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    set_random();
    step(1'b1, 1'b1, 1'b0);
    drain();
    $display("scenario clear done");

    // asynchronous reset in the middle of a stream
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 1'b0);
    #2;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    $display("scenario mid_reset done");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      set_random();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 99) < 2);
    end
    drain();
    $display("scenario random done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
